// File: rtl/sam_cfg_if.sv
// Pin-level bundle between the SAM serial config pins/core and the loader.
// The master side drives mode/str; the slave (the loader) returns the held configuration.
interface sam_cfg_if #(
    parameter int KMAX = 16
);
    logic            mode;
    logic            str;
    logic [3:0]      n;
    logic [10:0]     key_len;
    logic [KMAX-1:0] d;
    logic [KMAX-1:0] capsN;
    logic            cfg_valid;
    logic            cfg_err;
    logic            cfg_abort;

    modport master (
        output mode, str,
        input  n, key_len, d, capsN, cfg_valid, cfg_err, cfg_abort
    );

    modport slave (
        input  mode, str,
        output n, key_len, d, capsN, cfg_valid, cfg_err, cfg_abort
    );
endinterface

// File: rtl/sam_cfg_loader.sv
// SAM serial configuration loader: deserialises n, d, capsN (MSB first) while mode=1.
// Optional macro SAM_CFG_CHECK_EN adds value checks (capsN odd, d < capsN) at completion.
module sam_cfg_loader #(
    parameter int KMAX = 16
) (
    input  logic      clk,
    input  logic      reset,
    sam_cfg_if.slave  bus
);
    localparam int         LOG2K = $clog2(KMAX);
    localparam logic [3:0] NMAX  = 4'(LOG2K);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_N,
        LOAD_D,
        LOAD_CAPSN,
        DONE,
        ERROR
    } state_t;

    state_t          r_state,   w_state_nxt;
    logic [3:0]      r_n,       w_n_nxt;
    logic [10:0]     r_key_len, w_key_len_nxt;
    logic [10:0]     r_bit_cnt, w_bit_cnt_nxt;
    logic [KMAX-1:0] r_d,       w_d_nxt;
    logic [KMAX-1:0] r_capsn,   w_capsn_nxt;
    logic            r_valid,   w_valid_nxt;
    logic            r_err,     w_err_nxt;
    logic            r_abort,   w_abort_nxt;

    logic [3:0]      w_n_shift;
    logic [KMAX-1:0] w_d_shift;
    logic [KMAX-1:0] w_capsn_shift;
    logic            w_last_bit;
    logic            w_vals_ok;

    assign w_n_shift     = {r_n[2:0], bus.str};
    assign w_d_shift     = {r_d[KMAX-2:0], bus.str};
    assign w_capsn_shift = {r_capsn[KMAX-2:0], bus.str};
    assign w_last_bit    = (r_bit_cnt == 11'd1);

`ifdef SAM_CFG_CHECK_EN
    // Upper bits of both words are zero, so a full-width compare is exact.
    assign w_vals_ok = w_capsn_shift[0] && (r_d < w_capsn_shift);
`else
    assign w_vals_ok = 1'b1;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_n_nxt       = r_n;
        w_key_len_nxt = r_key_len;
        w_bit_cnt_nxt = r_bit_cnt;
        w_d_nxt       = r_d;
        w_capsn_nxt   = r_capsn;
        w_valid_nxt   = r_valid;
        w_err_nxt     = r_err;
        w_abort_nxt   = r_abort;

        case (r_state)
            IDLE: begin
                if (bus.mode) begin
                    w_n_nxt       = {3'b000, bus.str};
                    w_d_nxt       = '0;
                    w_capsn_nxt   = '0;
                    w_valid_nxt   = 1'b0;
                    w_err_nxt     = 1'b0;
                    w_abort_nxt   = 1'b0;
                    w_bit_cnt_nxt = 11'd3;
                    w_state_nxt   = LOAD_N;
                end
            end
            LOAD_N: begin
                if (!bus.mode) begin
                    w_abort_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_n_nxt       = w_n_shift;
                    w_bit_cnt_nxt = r_bit_cnt - 11'd1;
                    if (w_last_bit) begin
                        if (w_n_shift > NMAX) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ERROR;
                        end else begin
                            // n <= log2(KMAX) <= 10 here, so the shift fits 11 bits
                            w_key_len_nxt = 11'd1 << w_n_shift;
                            w_bit_cnt_nxt = 11'd1 << w_n_shift;
                            w_state_nxt   = LOAD_D;
                        end
                    end
                end
            end
            LOAD_D: begin
                if (!bus.mode) begin
                    w_abort_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_d_nxt       = w_d_shift;
                    w_bit_cnt_nxt = r_bit_cnt - 11'd1;
                    if (w_last_bit) begin
                        w_bit_cnt_nxt = r_key_len;
                        w_state_nxt   = LOAD_CAPSN;
                    end
                end
            end
            LOAD_CAPSN: begin
                if (!bus.mode) begin
                    w_abort_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_capsn_nxt   = w_capsn_shift;
                    w_bit_cnt_nxt = r_bit_cnt - 11'd1;
                    if (w_last_bit) begin
                        if (w_vals_ok) begin
                            w_valid_nxt = 1'b1;
                            w_state_nxt = DONE;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ERROR;
                        end
                    end
                end
            end
            DONE, ERROR: begin
                // Trailing str bits are ignored; only mode falling matters.
                if (!bus.mode) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_n       <= '0;
            r_key_len <= '0;
            r_bit_cnt <= '0;
            r_d       <= '0;
            r_capsn   <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_n       <= w_n_nxt;
            r_key_len <= w_key_len_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_d       <= w_d_nxt;
            r_capsn   <= w_capsn_nxt;
            r_valid   <= w_valid_nxt;
            r_err     <= w_err_nxt;
            r_abort   <= w_abort_nxt;
        end
    end

    assign bus.n         = r_n;
    assign bus.key_len   = r_key_len;
    assign bus.d         = r_d;
    assign bus.capsN     = r_capsn;
    assign bus.cfg_valid = r_valid;
    assign bus.cfg_err   = r_err;
    assign bus.cfg_abort = r_abort;
endmodule

// File: tb/tb_sam_cfg_loader.sv
// Bench for sam_cfg_loader: fixed vector table, hand-written reset/latency sequences,
// and random load sessions checked against a per-session outcome model.
module tb_sam_cfg_loader;
    localparam int KMAX = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    sam_cfg_if #(.KMAX(KMAX)) bus ();
    sam_cfg_loader #(.KMAX(KMAX)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int          w;      // posedges with mode=1
        logic [3:0]  n;
        logic [15:0] d;
        logic [15:0] c;
        logic        ev;     // expected cfg_valid
        logic        ee;     // expected cfg_err
        logic        ea;     // expected cfg_abort
        logic [15:0] ed;
        logic [15:0] ec;
        int          efv;    // edge where cfg_valid first rises, -1 if never
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(int w, logic [3:0] n, logic [15:0] d, logic [15:0] c,
                                logic ev, logic ee, logic ea, int efv);
        vec_t v;
        v.w = w; v.n = n; v.d = d; v.c = c;
        v.ev = ev; v.ee = ee; v.ea = ea;
        v.ed = (ee && n > 4) ? 16'h0 : d;
        v.ec = (ee && n > 4) ? 16'h0 : c;
        v.efv = efv;
        return v;
    endfunction

    // Outcome of one mode-high window, from the stream format alone.
    function automatic vec_t model(logic [3:0] n, logic [15:0] d, logic [15:0] c, int w);
        vec_t v;
        int   len;
        logic ok;
        v = mk(w, n, d, c, 1'b0, 1'b0, 1'b0, -1);
        if (w < 4) v.ea = 1'b1;
        else if ((1 << n) > KMAX) begin
            v.ee = 1'b1; v.ed = 16'h0; v.ec = 16'h0;
        end else begin
            len = 1 << n;
            if (w < 4 + 2 * len) v.ea = 1'b1;
            else begin
`ifdef SAM_CFG_CHECK_EN
                ok = c[0] && (d < c);
`else
                ok = 1'b1;
`endif
                if (ok) begin v.ev = 1'b1; v.efv = 4 + 2 * len; end
                else v.ee = 1'b1;
            end
        end
        return v;
    endfunction

    // Drives one window of w mode=1 cycles, then mode=0 until IDLE is sampled.
    task automatic session(input vec_t v, output int fv);
        logic bits[$];
        int   len;
        fv = -1;
        for (int k = 3; k >= 0; k--) bits.push_back(v.n[k]);
        if (v.n <= 4) begin
            len = 1 << v.n;
            for (int k = len - 1; k >= 0; k--) bits.push_back(v.d[k]);
            for (int k = len - 1; k >= 0; k--) bits.push_back(v.c[k]);
        end
        while (bits.size() < v.w) bits.push_back(1'($urandom));
        for (int i = 0; i <= v.w; i++) begin
            @(negedge clk);
            if (i >= 1 && bus.cfg_valid && fv < 0) fv = i;
            if (i < v.w) begin bus.mode = 1'b1; bus.str = bits[i]; end
            else begin bus.mode = 1'b0; bus.str = 1'($urandom); end
        end
        @(negedge clk);
    endtask

    task automatic apply(input vec_t v, input string tag);
        int fv;
        session(v, fv);
        chk({tag, ".valid"}, 32'(bus.cfg_valid), 32'(v.ev));
        chk({tag, ".err"},   32'(bus.cfg_err),   32'(v.ee));
        chk({tag, ".abort"}, 32'(bus.cfg_abort), 32'(v.ea));
        chk({tag, ".vlat"},  32'(fv),            32'(v.efv));
        if (v.w >= 4) chk({tag, ".n"}, 32'(bus.n), 32'(v.n));
        if (v.ev) chk({tag, ".key_len"}, 32'(bus.key_len), 32'(1) << v.n);
        if (v.ev || v.ee) begin
            chk({tag, ".d"},     32'(bus.d),     32'(v.ed));
            chk({tag, ".capsN"}, 32'(bus.capsN), 32'(v.ec));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".n"},       32'(bus.n),         32'h0);
        chk({tag, ".key_len"}, 32'(bus.key_len),   32'h0);
        chk({tag, ".d"},       32'(bus.d),         32'h0);
        chk({tag, ".capsN"},   32'(bus.capsN),     32'h0);
        chk({tag, ".flags"},   {29'h0, bus.cfg_valid, bus.cfg_err, bus.cfg_abort}, 32'h0);
    endtask

    vec_t tbl[9];

    initial begin
        bus.mode = 1'b0;
        bus.str  = 1'b0;

        tbl[0] = mk(21, 4'd3,  16'h00A5, 16'h00C3, 1, 0, 0, 20);
        tbl[1] = mk(8,  4'd5,  16'h0000, 16'h0000, 0, 1, 0, -1);
        tbl[2] = mk(10, 4'd3,  16'h00A5, 16'h00C3, 0, 0, 1, -1);
        tbl[3] = mk(12, 4'd2,  16'h0009, 16'h000B, 1, 0, 0, 12);
        tbl[4] = mk(8,  4'd1,  16'h0001, 16'h0003, 1, 0, 0, 8);
`ifdef SAM_CFG_CHECK_EN
        tbl[5] = mk(12, 4'd2,  16'h0009, 16'h0008, 0, 1, 0, -1);
`else
        tbl[5] = mk(12, 4'd2,  16'h0009, 16'h0008, 1, 0, 0, 12);
`endif
        tbl[6] = mk(38, 4'd4,  16'hBEEF, 16'hFFFF, 1, 0, 0, 36);
        tbl[7] = mk(4,  4'd15, 16'h0000, 16'h0000, 0, 1, 0, -1);
        tbl[8] = mk(2,  4'd2,  16'h0009, 16'h000B, 0, 0, 1, -1);

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("idle");

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Reset pulsed mid-capsN: n=3, d=A5, then two capsN bits, then async reset.
        begin
            logic [15:0] s;
            s = 16'h3A5C;
            for (int i = 0; i < 14; i++) begin
                @(negedge clk);
                bus.mode = 1'b1;
                bus.str  = s[15 - i];
            end
            @(posedge clk);
            #2 reset = 1'b0;
            #1 chk_all_zero("rst_mid");
            @(negedge clk);
            bus.mode = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            chk_all_zero("rst_after");
            apply(tbl[3], "rst_reload");
        end

        for (int r = 0; r < 60; r++) begin
            logic [3:0]  n;
            logic [15:0] d, c, mask;
            int          len, full, w;
            n = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
            len  = (n <= 4) ? (1 << n) : 1;
            mask = (n <= 4) ? 16'((32'h1 << len) - 1) : 16'h0;
            d = 16'($urandom) & mask;
            c = 16'($urandom) & mask;
            full = (n <= 4) ? 4 + 2 * len : 4;
            if ($urandom_range(0, 3) == 0 && full > 1) w = $urandom_range(1, full - 1);
            else w = full + $urandom_range(0, 2);
            apply(model(n, d, c, w), $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
